// File: rtl/esp_resp_parser.sv
`default_nettype none
// ============================================================================
//  Module      : esp_resp_parser
//  Description : Splits ESP8266 AT-response bytes into CR/LF lines, pulses on
//                "OK" / "ERROR" / "ready", and streams "+IPD,<len>:" payloads
//                with first/last markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module esp_resp_parser #(
  parameter int MAX_LEN    = 1460,
  parameter int LEN_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_vld,
  output logic        resp_ok,
  output logic        resp_err,
  output logic        resp_rdy,
  output logic        hdr_err,
  output logic [7:0]  pl_data,
  output logic        pl_vld,
  output logic        pl_first,
  output logic        pl_last,
  output logic [10:0] pl_len
);

  localparam int          DW           = $clog2(LEN_DIGITS + 1);
  localparam logic [13:0] c_max_len    = 14'(MAX_LEN);
  localparam logic [DW-1:0] c_len_digits = DW'(LEN_DIGITS);
  localparam logic [7:0]  c_cr         = 8'h0D;
  localparam logic [7:0]  c_lf         = 8'h0A;

  typedef enum logic [1:0] {
    S_LINE    = 2'd0,
    S_LEN     = 2'd1,
    S_SKIP    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [7:0]      line_q [5];
  logic [7:0]      line_d [5];
  logic [13:0]     acc_q, acc_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic [10:0]     rem_q, rem_d;
  logic            resp_ok_d, resp_err_d, resp_rdy_d, hdr_err_d;
  logic [7:0]      pl_data_d;
  logic            pl_vld_d, pl_first_d, pl_last_d;
  logic [10:0]     pl_len_d;

  logic            w_is_digit;
  logic            w_line_ok, w_line_err, w_line_rdy, w_ipd_prefix;

  assign w_is_digit   = (din >= 8'h30) && (din <= 8'h39);
  // Only the first five characters are kept, so the length check makes the
  // comparison exact (longer lines with a matching prefix do not qualify).
  assign w_line_ok    = (cnt_q == 6'd2) && (line_q[0] == "O") && (line_q[1] == "K");
  assign w_line_err   = (cnt_q == 6'd5) && (line_q[0] == "E") && (line_q[1] == "R") &&
                        (line_q[2] == "R") && (line_q[3] == "O") && (line_q[4] == "R");
  assign w_line_rdy   = (cnt_q == 6'd5) && (line_q[0] == "r") && (line_q[1] == "e") &&
                        (line_q[2] == "a") && (line_q[3] == "d") && (line_q[4] == "y");
  assign w_ipd_prefix = (cnt_q == 6'd4) && (line_q[0] == "+") && (line_q[1] == "I") &&
                        (line_q[2] == "P") && (line_q[3] == "D") && (din == ",");

  // Next-state and registered-output decode; acts only on valid bytes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    acc_d      = acc_q;
    dig_d      = dig_q;
    rem_d      = rem_q;
    resp_ok_d  = 1'b0;
    resp_err_d = 1'b0;
    resp_rdy_d = 1'b0;
    hdr_err_d  = 1'b0;
    pl_vld_d   = 1'b0;
    pl_first_d = 1'b0;
    pl_last_d  = 1'b0;
    pl_data_d  = pl_data;
    pl_len_d   = pl_len;

    if (din_vld) begin
      case (state_q)
        S_LINE: begin
          if (din == c_lf) begin
            resp_ok_d  = w_line_ok;
            resp_err_d = w_line_err;
            resp_rdy_d = w_line_rdy;
            cnt_d      = 6'd0;
            for (int i = 0; i < 5; i++) line_d[i] = 8'h00;
          end else if (din != c_cr) begin
            if (w_ipd_prefix) begin
              // Header recognised: start a fresh length field.
              state_d = S_LEN;
              acc_d   = 14'd0;
              dig_d   = '0;
              cnt_d   = 6'd0;
              for (int i = 0; i < 5; i++) line_d[i] = 8'h00;
            end else begin
              if (cnt_q < 6'd5) line_d[cnt_q[2:0]] = din;
              if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
            end
          end
        end

        S_LEN: begin
          if (w_is_digit) begin
            if (dig_q == c_len_digits) begin
              hdr_err_d = 1'b1;
              state_d   = S_SKIP;
            end else begin
              acc_d = acc_q * 14'd10 + {10'd0, din[3:0]};
              dig_d = dig_q + 1'b1;
            end
          end else if (din == ":") begin
            if (dig_q == '0) begin
              hdr_err_d = 1'b1;
              state_d   = S_SKIP;
            end else if (acc_q == 14'd0) begin
              state_d = S_LINE;
            end else if (acc_q > c_max_len) begin
              hdr_err_d = 1'b1;
              state_d   = S_SKIP;
            end else begin
              pl_len_d = acc_q[10:0];
              rem_d    = acc_q[10:0];
              state_d  = S_PAYLOAD;
            end
          end else begin
            hdr_err_d = 1'b1;
            state_d   = (din == c_lf) ? S_LINE : S_SKIP;
          end
        end

        S_SKIP: begin
          if (din == c_lf) state_d = S_LINE;
        end

        S_PAYLOAD: begin
          // Payload is opaque: CR/LF are data here.
          pl_vld_d   = 1'b1;
          pl_data_d  = din;
          pl_first_d = (rem_q == pl_len);
          pl_last_d  = (rem_q == 11'd1);
          rem_d      = rem_q - 11'd1;
          if (rem_q == 11'd1) state_d = S_LINE;
        end

        default: state_d = S_LINE;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LINE;
      cnt_q    <= 6'd0;
      for (int i = 0; i < 5; i++) line_q[i] <= 8'h00;
      acc_q    <= 14'd0;
      dig_q    <= '0;
      rem_q    <= 11'd0;
      resp_ok  <= 1'b0;
      resp_err <= 1'b0;
      resp_rdy <= 1'b0;
      hdr_err  <= 1'b0;
      pl_data  <= 8'h00;
      pl_vld   <= 1'b0;
      pl_first <= 1'b0;
      pl_last  <= 1'b0;
      pl_len   <= 11'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      acc_q    <= acc_d;
      dig_q    <= dig_d;
      rem_q    <= rem_d;
      resp_ok  <= resp_ok_d;
      resp_err <= resp_err_d;
      resp_rdy <= resp_rdy_d;
      hdr_err  <= hdr_err_d;
      pl_data  <= pl_data_d;
      pl_vld   <= pl_vld_d;
      pl_first <= pl_first_d;
      pl_last  <= pl_last_d;
      pl_len   <= pl_len_d;
    end
  end

endmodule
`default_nettype wire
